// File: rtl/stage_execute_mc.sv
// Multi-cycle execute stage: RV32I/RV64I ALU, branch resolution and write-back qualifiers behind a
// registered valid/ready output. Define EXEC_MULDIV_EN to compile in the RV-M multiplier and divider.
module stage_execute_mc #(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] pc,
   input  logic [6:0]      opcode,
   input  logic [2:0]      funct3,
   input  logic [6:0]      funct7,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic [XLEN-1:0] imm,
   input  logic [SHW-1:0]  shamt,
   input  logic [4:0]      addr_rd,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] alu_res,
   output logic            br_taken,
   output logic            reg_write_back,
   output logic            dmem_read_write,
   output logic [4:0]      out_rd,
   output logic            busy
);
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_e;

   state_e          state_q;
   logic            out_valid_q, br_q, wb_q, st_q;
   logic [XLEN-1:0] alu_res_q;
   logic [4:0]      rd_q;

   logic            accept, is_op, is_m, take;
   logic [XLEN-1:0] opb, alu_c, res_c;
   logic signed [XLEN-1:0] sra_c;
   logic [SHW-1:0]  sh;
   logic            br_c, wb_c, st_c;

   assign in_ready        = (state_q == S_IDLE) && (!out_valid_q || out_ready);
   assign accept          = in_valid && in_ready && !flush;
   assign out_valid       = out_valid_q;
   assign alu_res         = alu_res_q;
   assign br_taken        = br_q;
   assign reg_write_back  = wb_q;
   assign dmem_read_write = st_q;
   assign out_rd          = rd_q;

   assign is_op = (opcode == OPC_OP);
   assign is_m  = is_op && (funct7 == 7'b0000001);

`ifdef EXEC_MULDIV_EN
   logic [SHW-1:0]  cnt_q;
   logic [XLEN-1:0] rem_q, quo_q, dvs_q, drd_res;
   logic [4:0]      drd_q;
   logic            neg_q_q, neg_r_q, rem_sel_q;

   logic signed [2*XLEN-1:0] ma, mb, prod;
   logic [XLEN-1:0] mul_c, a_mag, b_mag, div_spec_c, q_fin, r_fin, rem_n, quo_n;
   logic [XLEN:0]   trial;
   logic            div_sgn, a_neg, b_neg, dz, ovf, start_div;

   assign busy = (state_q != S_IDLE);

   always_comb begin
      // Operands widened to 2*XLEN so one signed multiply covers all four signedness mixes
      ma    = {{XLEN{(funct3 != 3'b011) & rs1[XLEN-1]}}, rs1};
      mb    = {{XLEN{!funct3[1] & rs2[XLEN-1]}}, rs2};
      prod  = ma * mb;
      mul_c = (funct3 == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

      div_sgn = !funct3[0];
      a_neg   = div_sgn & rs1[XLEN-1];
      b_neg   = div_sgn & rs2[XLEN-1];
      a_mag   = a_neg ? -rs1 : rs1;
      b_mag   = b_neg ? -rs2 : rs2;
      dz      = (rs2 == '0);
      ovf     = div_sgn && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
      if (dz)       div_spec_c = funct3[1] ? rs1 : '1;
      else if (ovf) div_spec_c = funct3[1] ? '0 : rs1;
      else          div_spec_c = '0;
      start_div = is_m && funct3[2] && !dz && !ovf;

      // Restoring step: remainder stays below the divisor, so trial[XLEN] is a clean borrow
      trial = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
      if (!trial[XLEN]) begin
         rem_n = trial[XLEN-1:0];
         quo_n = {quo_q[XLEN-2:0], 1'b1};
      end else begin
         rem_n = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
         quo_n = {quo_q[XLEN-2:0], 1'b0};
      end
      q_fin   = neg_q_q ? -quo_q : quo_q;
      r_fin   = neg_r_q ? -rem_q : rem_q;
      drd_res = rem_sel_q ? r_fin : q_fin;
   end
`else
   assign busy = 1'b0;
`endif

   always_comb begin
      opb   = is_op ? rs2 : imm;
      sh    = is_op ? rs2[SHW-1:0] : shamt;
      sra_c = $signed(rs1) >>> sh;
      case (funct3)
         3'b000:  alu_c = (is_op && funct7[5]) ? rs1 - opb : rs1 + opb;
         3'b001:  alu_c = rs1 << sh;
         3'b010:  alu_c = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(opb))};
         3'b011:  alu_c = {{(XLEN-1){1'b0}}, (rs1 < opb)};
         3'b100:  alu_c = rs1 ^ opb;
         3'b101:  alu_c = funct7[5] ? sra_c : rs1 >> sh;
         3'b110:  alu_c = rs1 | opb;
         default: alu_c = rs1 & opb;
      endcase

      case (funct3)
         3'b000:  take = (rs1 == rs2);
         3'b001:  take = (rs1 != rs2);
         3'b100:  take = ($signed(rs1) < $signed(rs2));
         3'b101:  take = ($signed(rs1) >= $signed(rs2));
         3'b110:  take = (rs1 < rs2);
         3'b111:  take = (rs1 >= rs2);
         default: take = 1'b0;
      endcase

      res_c = '0;
      br_c  = 1'b0;
      wb_c  = 1'b0;
      st_c  = 1'b0;
      case (opcode)
         OPC_LUI:    begin res_c = imm;      wb_c = 1'b1; end
         OPC_AUIPC:  begin res_c = pc + imm; wb_c = 1'b1; end
         OPC_JAL:    begin res_c = pc + imm; wb_c = 1'b1; br_c = 1'b1; end
         OPC_JALR:   begin res_c = rs1 + imm; wb_c = 1'b1; br_c = 1'b1; end
         OPC_BRANCH: begin res_c = pc + imm; br_c = take; end
         OPC_LOAD:   begin res_c = rs1 + imm; wb_c = 1'b1; end
         OPC_STORE:  begin res_c = rs1 + imm; st_c = 1'b1; end
         OPC_OPIMM:  begin res_c = alu_c;    wb_c = 1'b1; end
         OPC_OP: begin
            if (is_m) begin
`ifdef EXEC_MULDIV_EN
               res_c = funct3[2] ? div_spec_c : mul_c;
               wb_c  = 1'b1;
`else
               res_c = '0;
               wb_c  = 1'b0;
`endif
            end else begin
               res_c = alu_c;
               wb_c  = 1'b1;
            end
         end
         default: ;
      endcase
      if (addr_rd == 5'd0) wb_c = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         out_valid_q <= 1'b0;
         alu_res_q   <= '0;
         br_q        <= 1'b0;
         wb_q        <= 1'b0;
         st_q        <= 1'b0;
         rd_q        <= '0;
`ifdef EXEC_MULDIV_EN
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         drd_q     <= '0;
         neg_q_q   <= 1'b0;
         neg_r_q   <= 1'b0;
         rem_sel_q <= 1'b0;
`endif
      end else if (flush) begin
         state_q     <= S_IDLE;
         out_valid_q <= 1'b0;
`ifdef EXEC_MULDIV_EN
         cnt_q <= '0;
`endif
      end else begin
         if (out_ready) out_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
`ifdef EXEC_MULDIV_EN
                  if (start_div) begin
                     state_q   <= S_DIV;
                     cnt_q     <= '0;
                     rem_q     <= '0;
                     quo_q     <= a_mag;
                     dvs_q     <= b_mag;
                     neg_q_q   <= a_neg ^ b_neg;
                     neg_r_q   <= a_neg;
                     rem_sel_q <= funct3[1];
                     drd_q     <= addr_rd;
                  end else
`endif
                  begin
                     alu_res_q   <= res_c;
                     br_q        <= br_c;
                     wb_q        <= wb_c;
                     st_q        <= st_c;
                     rd_q        <= addr_rd;
                     out_valid_q <= 1'b1;
                  end
               end
            end
`ifdef EXEC_MULDIV_EN
            S_DIV: begin
               rem_q <= rem_n;
               quo_q <= quo_n;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == SHW'(XLEN-1)) state_q <= S_DONE;
            end
            S_DONE: begin
               if (!out_valid_q || out_ready) begin
                  alu_res_q   <= drd_res;
                  br_q        <= 1'b0;
                  wb_q        <= (drd_q != 5'd0);
                  st_q        <= 1'b0;
                  rd_q        <= drd_q;
                  out_valid_q <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
`endif
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_stage_execute_mc.sv
// Scoreboard bench for stage_execute_mc: expected results queued at acceptance, compared on consume.
module tb_stage_execute_mc;
   localparam int XLEN = 32;
   localparam int SHW  = 5;
   localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LUI = 7'b0110111, AUIPC = 7'b0010111;
   localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111, BR = 7'b1100011, LD = 7'b0000011;
   localparam logic [6:0] ST = 7'b0100011, SYS = 7'b1110011;
   localparam logic [6:0] F7M = 7'b0000001, F7A = 7'b0100000;

   typedef struct {
      logic [6:0] opc; logic [2:0] f3; logic [6:0] f7;
      logic [31:0] a, b, imm, pc; logic [4:0] sh, rd;
   } req_t;
   typedef struct { logic [31:0] res; logic br, wb, st; logic [4:0] rd; } exp_t;

   logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic in_ready, out_valid, br_taken, reg_write_back, dmem_read_write, busy;
   logic [XLEN-1:0] pc = '0, rs1 = '0, rs2 = '0, imm = '0, alu_res;
   logic [6:0] opcode = '0, funct7 = '0;
   logic [2:0] funct3 = '0;
   logic [SHW-1:0] shamt = '0;
   logic [4:0] addr_rd = '0, out_rd;

   int   vectors = 0, miscompares = 0;
   bit   mon_en = 1'b1;
   exp_t sb[$];
   exp_t mon_e;

   stage_execute_mc #(.XLEN(XLEN), .SHW(SHW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .pc(pc), .opcode(opcode), .funct3(funct3), .funct7(funct7), .rs1(rs1), .rs2(rs2),
      .imm(imm), .shamt(shamt), .addr_rd(addr_rd), .out_valid(out_valid), .out_ready(out_ready),
      .alu_res(alu_res), .br_taken(br_taken), .reg_write_back(reg_write_back),
      .dmem_read_write(dmem_read_write), .out_rd(out_rd), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   always @(negedge clk) begin
      if (rst_n && mon_en && out_valid && out_ready) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL sb_extra: got res=%h rd=%0d, need no output", alu_res, out_rd);
         end else begin
            mon_e = sb.pop_front();
            if ({alu_res, br_taken, reg_write_back, dmem_read_write, out_rd} !==
                {mon_e.res, mon_e.br, mon_e.wb, mon_e.st, mon_e.rd}) begin
               miscompares++;
               $display("FAIL result: got res=%h br=%b wb=%b st=%b rd=%0d, need res=%h br=%b wb=%b st=%b rd=%0d",
                        alu_res, br_taken, reg_write_back, dmem_read_write, out_rd,
                        mon_e.res, mon_e.br, mon_e.wb, mon_e.st, mon_e.rd);
            end
         end
      end
   end

   function automatic req_t R(logic [6:0] opc, logic [2:0] f3, logic [6:0] f7,
                              logic [31:0] a, logic [31:0] b, logic [31:0] im, logic [31:0] p,
                              logic [4:0] sh, logic [4:0] rd);
      req_t r;
      r.opc = opc; r.f3 = f3; r.f7 = f7; r.a = a; r.b = b; r.imm = im; r.pc = p; r.sh = sh; r.rd = rd;
      return r;
   endfunction

   function automatic exp_t E(logic [31:0] res, logic br, logic wb, logic st, logic [4:0] rd);
      exp_t e;
      e.res = res; e.br = br; e.wb = wb; e.st = st; e.rd = rd;
      return e;
   endfunction

   task automatic drive(input req_t r);
      opcode = r.opc; funct3 = r.f3; funct7 = r.f7; rs1 = r.a; rs2 = r.b;
      imm = r.imm; pc = r.pc; shamt = r.sh; addr_rd = r.rd; in_valid = 1'b1;
   endtask

   task automatic send(input req_t r, input exp_t e);
      int n = 0;
      drive(r);
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         vectors++; miscompares++;
         $display("FAIL send_timeout: in_ready=%b after %0d cycles, need 1", in_ready, n);
      end else sb.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic lat1(input string name, input logic [31:0] res);
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || alu_res !== res || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_lat1: got valid=%b res=%h busy=%b, need valid=1 res=%h busy=0",
                  name, out_valid, alu_res, busy, res);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({out_valid, alu_res, br_taken, reg_write_back, dmem_read_write, out_rd, busy} !== '0) begin
         miscompares++;
         $display("FAIL reset_outs: got valid=%b res=%h busy=%b rd=%0d, need all 0", out_valid, alu_res, busy, out_rd);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_ready: got %b, need 1", in_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      out_ready = 1'b1;
      drive(R(OP, 3'b000, 7'h00, 32'd5, 32'hFFFF_FFFD, 32'd0, 32'd0, 5'd0, 5'd1));
      @(negedge clk);
      sb.push_back(E(32'd2, 1'b0, 1'b1, 1'b0, 5'd1));
      @(posedge clk); #1;
      drive(R(OPI, 3'b101, F7A, 32'h8000_0000, 32'd0, 32'h404, 32'd0, 5'd4, 5'd2));
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || alu_res !== 32'd2 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL add_b2b: got valid=%b res=%h ready=%b, need 1 00000002 1", out_valid, alu_res, in_ready);
      end
      sb.push_back(E(32'hF800_0000, 1'b0, 1'b1, 1'b0, 5'd2));
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || alu_res !== 32'hF800_0000) begin
         miscompares++;
         $display("FAIL srai_b2b: got valid=%b res=%h, need 1 f8000000", out_valid, alu_res);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_branch;
      send(R(BR, 3'b100, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd0, 5'd0), E(32'h120, 1'b1, 1'b0, 1'b0, 5'd0));
      send(R(BR, 3'b110, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd0, 5'd0), E(32'h120, 1'b0, 1'b0, 1'b0, 5'd0));
      send(R(BR, 3'b001, 7'h00, 32'd1, 32'd2, 32'h8, 32'h200, 5'd0, 5'd0), E(32'h208, 1'b1, 1'b0, 1'b0, 5'd0));
      send(R(BR, 3'b101, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'h200, 5'd0, 5'd0), E(32'h208, 1'b0, 1'b0, 1'b0, 5'd0));
      send(R(BR, 3'b111, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'h200, 5'd0, 5'd0), E(32'h208, 1'b1, 1'b0, 1'b0, 5'd0));
      send(R(BR, 3'b010, 7'h00, 32'd4, 32'd4, 32'h8, 32'h200, 5'd0, 5'd0), E(32'h208, 1'b0, 1'b0, 1'b0, 5'd0));
   endtask

   task automatic test_base_ops;
      send(R(OP,  3'b000, F7A,   32'd10, 32'd3, 32'd0, 32'd0, 5'd0, 5'd4), E(32'd7, 1'b0, 1'b1, 1'b0, 5'd4));
      send(R(OP,  3'b010, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd0, 5'd5), E(32'd1, 1'b0, 1'b1, 1'b0, 5'd5));
      send(R(OP,  3'b011, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd0, 5'd5), E(32'd0, 1'b0, 1'b1, 1'b0, 5'd5));
      send(R(OPI, 3'b011, 7'h00, 32'd3, 32'd0, 32'hFFFF_FFFF, 32'd0, 5'd0, 5'd6), E(32'd1, 1'b0, 1'b1, 1'b0, 5'd6));
      send(R(OP,  3'b001, 7'h00, 32'd1, 32'd33, 32'd0, 32'd0, 5'd0, 5'd7), E(32'd2, 1'b0, 1'b1, 1'b0, 5'd7));
      send(R(OP,  3'b101, 7'h00, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 5'd0, 5'd8), E(32'h0800_0000, 1'b0, 1'b1, 1'b0, 5'd8));
      send(R(OP,  3'b101, F7A,   32'h8000_0000, 32'd4, 32'd0, 32'd0, 5'd0, 5'd8), E(32'hF800_0000, 1'b0, 1'b1, 1'b0, 5'd8));
      send(R(OPI, 3'b100, 7'h00, 32'hF0F0_0000, 32'd0, 32'h0000_0FF0, 32'd0, 5'd0, 5'd9), E(32'hF0F0_0FF0, 1'b0, 1'b1, 1'b0, 5'd9));
      send(R(OPI, 3'b000, F7A,   32'd10, 32'd0, 32'd5, 32'd0, 5'd0, 5'd9), E(32'd15, 1'b0, 1'b1, 1'b0, 5'd9));
      send(R(LUI, 3'b000, 7'h00, 32'd0, 32'd0, 32'h1234_5000, 32'd0, 5'd0, 5'd0), E(32'h1234_5000, 1'b0, 1'b0, 1'b0, 5'd0));
      send(R(AUIPC, 3'b000, 7'h00, 32'd0, 32'd0, 32'h1000, 32'h40, 5'd0, 5'd3), E(32'h1040, 1'b0, 1'b1, 1'b0, 5'd3));
      send(R(JAL, 3'b000, 7'h00, 32'd0, 32'd0, 32'h80, 32'h400, 5'd0, 5'd1), E(32'h480, 1'b1, 1'b1, 1'b0, 5'd1));
      send(R(JALR, 3'b000, 7'h00, 32'h1000, 32'd0, 32'hFFFF_FFFC, 32'h400, 5'd0, 5'd1), E(32'hFFC, 1'b1, 1'b1, 1'b0, 5'd1));
      send(R(LD, 3'b010, 7'h00, 32'h2000, 32'd0, 32'h10, 32'd0, 5'd0, 5'd12), E(32'h2010, 1'b0, 1'b1, 1'b0, 5'd12));
      send(R(ST, 3'b010, 7'h00, 32'h2000, 32'd99, 32'h8, 32'd0, 5'd0, 5'd0), E(32'h2008, 1'b0, 1'b0, 1'b1, 5'd0));
      send(R(SYS, 3'b000, 7'h00, 32'd5, 32'd6, 32'd0, 32'd0, 5'd0, 5'd5), E(32'd0, 1'b0, 1'b0, 1'b0, 5'd5));
      lat1("ecall", 32'd0);
   endtask

   task automatic test_muldiv;
`ifdef EXEC_MULDIV_EN
      int lo = 0, bz = 0;
      send(R(OP, 3'b000, F7M, 32'd3, 32'd4, 32'd0, 32'd0, 5'd0, 5'd5), E(32'd12, 1'b0, 1'b1, 1'b0, 5'd5));
      send(R(OP, 3'b001, F7M, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd0, 5'd5), E(32'd0, 1'b0, 1'b1, 1'b0, 5'd5));
      send(R(OP, 3'b011, F7M, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd0, 5'd5), E(32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 5'd5));
      send(R(OP, 3'b010, F7M, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd0, 5'd5), E(32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 5'd5));
      send(R(OP, 3'b101, F7M, 32'h1234, 32'd0, 32'd0, 32'd0, 5'd0, 5'd6), E(32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 5'd6));
      lat1("divu_zero", 32'hFFFF_FFFF);
      send(R(OP, 3'b111, F7M, 32'h1234, 32'd0, 32'd0, 32'd0, 5'd0, 5'd6), E(32'h1234, 1'b0, 1'b1, 1'b0, 5'd6));
      send(R(OP, 3'b100, F7M, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd0, 5'd7), E(32'h8000_0000, 1'b0, 1'b1, 1'b0, 5'd7));
      lat1("div_ovf", 32'h8000_0000);
      send(R(OP, 3'b110, F7M, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd0, 5'd7), E(32'd0, 1'b0, 1'b1, 1'b0, 5'd7));
      repeat (2) @(posedge clk);
      #1;
      drive(R(OP, 3'b100, F7M, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 5'd0, 5'd10));
      @(negedge clk);
      sb.push_back(E(32'hFFFF_FFFD, 1'b0, 1'b1, 1'b0, 5'd10));
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (out_valid) break;
         if (!in_ready) lo++;
         if (busy) bz++;
      end
      vectors++;
      if (out_valid !== 1'b1 || alu_res !== 32'hFFFF_FFFD || lo != XLEN + 1 || bz != XLEN + 1) begin
         miscompares++;
         $display("FAIL div_timing: got valid=%b res=%h stall=%0d busy=%0d, need 1 fffffffd %0d %0d",
                  out_valid, alu_res, lo, bz, XLEN + 1, XLEN + 1);
      end
      @(posedge clk); #1;
      send(R(OP, 3'b110, F7M, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 5'd0, 5'd11), E(32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 5'd11));
      send(R(OP, 3'b101, F7M, 32'd100, 32'd7, 32'd0, 32'd0, 5'd0, 5'd12), E(32'd14, 1'b0, 1'b1, 1'b0, 5'd12));
      send(R(OP, 3'b111, F7M, 32'd100, 32'd7, 32'd0, 32'd0, 5'd0, 5'd0), E(32'd2, 1'b0, 1'b0, 1'b0, 5'd0));
      send(R(OP, 3'b100, F7M, 32'd7, 32'hFFFF_FFFE, 32'd0, 32'd0, 5'd0, 5'd13), E(32'hFFFF_FFFD, 1'b0, 1'b1, 1'b0, 5'd13));
      repeat (40) @(posedge clk);
      #1;
`else
      send(R(OP, 3'b000, F7M, 32'd3, 32'd4, 32'd0, 32'd0, 5'd0, 5'd5), E(32'd0, 1'b0, 1'b0, 1'b0, 5'd5));
      lat1("mul_off", 32'd0);
      send(R(OP, 3'b100, F7M, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 5'd0, 5'd6), E(32'd0, 1'b0, 1'b0, 1'b0, 5'd6));
      lat1("div_off", 32'd0);
`endif
   endtask

   task automatic test_hold;
      out_ready = 1'b0;
      send(R(OP, 3'b000, 7'h00, 32'd1, 32'd2, 32'd0, 32'd0, 5'd0, 5'd3), E(32'd3, 1'b0, 1'b1, 1'b0, 5'd3));
      drive(R(OP, 3'b000, 7'h00, 32'd10, 32'd20, 32'd0, 32'd0, 5'd0, 5'd7));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         vectors++;
         if (out_valid !== 1'b1 || alu_res !== 32'd3 || out_rd !== 5'd3 || reg_write_back !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_%0d: got valid=%b res=%h rd=%0d ready=%b, need 1 00000003 3 0",
                     i, out_valid, alu_res, out_rd, in_ready);
         end
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(R(OP, 3'b000, 7'h00, 32'd10, 32'd20, 32'd0, 32'd0, 5'd0, 5'd7), E(32'd30, 1'b0, 1'b1, 1'b0, 5'd7));
      lat1("after_hold", 32'd30);
   endtask

   task automatic test_flush;
      int bad = 0;
      mon_en = 1'b0;
      out_ready = 1'b0;
      drive(R(OP, 3'b000, 7'h00, 32'd1, 32'd2, 32'd0, 32'd0, 5'd0, 5'd3));
      @(posedge clk); #1;
      drive(R(OP, 3'b000, 7'h00, 32'd10, 32'd20, 32'd0, 32'd0, 5'd0, 5'd7));
      out_ready = 1'b1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_kill: got valid=%b res=%h, need valid=0", out_valid, alu_res);
      end
      @(posedge clk); #1;
      mon_en = 1'b1;
`ifdef EXEC_MULDIV_EN
      drive(R(OP, 3'b101, F7M, 32'd100, 32'd7, 32'd0, 32'd0, 5'd0, 5'd9));
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL flush_pre_busy: got %b, need 1", busy);
      end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid || busy || !in_ready) bad++;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL flush_div: got %0d cycles with valid/busy/stall, need 0", bad);
      end
      @(posedge clk); #1;
`endif
      send(R(OP, 3'b000, 7'h00, 32'd7, 32'd8, 32'd0, 32'd0, 5'd0, 5'd9), E(32'd15, 1'b0, 1'b1, 1'b0, 5'd9));
      lat1("post_flush", 32'd15);
   endtask

   task automatic test_reset_mid;
`ifdef EXEC_MULDIV_EN
      drive(R(OP, 3'b101, F7M, 32'd100, 32'd7, 32'd0, 32'd0, 5'd0, 5'd9));
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_pre_busy: got %b, need 1", busy);
      end
`else
      out_ready = 1'b0;
      drive(R(OP, 3'b000, 7'h00, 32'd1, 32'd2, 32'd0, 32'd0, 5'd0, 5'd3));
      @(posedge clk); #1;
      in_valid = 1'b0;
      vectors++;
      if (out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_pre_valid: got %b, need 1", out_valid);
      end
`endif
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({out_valid, alu_res, br_taken, reg_write_back, dmem_read_write, out_rd, busy} !== '0) begin
         miscompares++;
         $display("FAIL rst_mid_outs: got valid=%b res=%h busy=%b rd=%0d, need all 0", out_valid, alu_res, busy, out_rd);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_mid_ready: got ready=%b valid=%b busy=%b, need 1 0 0", in_ready, out_valid, busy);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_branch();
      test_base_ops();
      test_muldiv();
      test_hold();
      test_flush();
      test_reset_mid();
      repeat (3) @(posedge clk);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL sb_leftover: got %0d pending results, need 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
